rc_frame_parser: RTL and testbench
==================================

Name: rc_frame_parser

Overview:
- Upstream command stage for the flight controller. Consumes bytes from the UART receiver (async_receiver `RxD_data_ready`/`RxD_data`).
- Parses fixed-length command frames and range-checks the four targets: height, pitch, roll, yaw.
- Publishes the targets with a one-cycle renew strobe to the top-level target registers.
- Runs a link watchdog that forces safe zero targets when the ground link goes silent.

Parameters:
- BYTE_TIMEOUT, 50000: max idle clk cycles between bytes inside a frame before abort (1 ms at 50 MHz).
- LINK_TIMEOUT, 25000000: clk cycles without a valid frame before link loss (0.5 s).
- ANGLE_LIMIT, 3000: symmetric clamp for pitch/roll/yaw targets (0.01 deg units, ±30 deg).
- HEIGHT_MAX, 200000: upper clamp for height target (mm).

Ports:
- clk, input, 1: 50 MHz system clock.
- rst_n, input, 1: synchronous, active-high reset (1 = reset).
- rx_data, input, 8: received byte.
- rx_valid, input, 1: one-cycle strobe, rx_data valid.
- target_renew, output, 1: one-cycle pulse, targets updated this cycle.
- target_height, output, 24: signed height target.
- target_pitch, output, 24: signed pitch target.
- target_roll, output, 24: signed roll target.
- target_yaw, output, 24: signed yaw target.
- frame_err, output, 1: one-cycle pulse on checksum fail or byte timeout.
- link_lost, output, 1: level, no valid frame within LINK_TIMEOUT.
- frame_cnt, output, 8: count of accepted frames, wraps 255 -> 0.

Behaviour:
Frame format, 15 bytes:
- 0xAA, 0x55 header.
- 12 payload bytes: height, pitch, roll, yaw, each 24-bit two's complement, big-endian.
- 1 checksum byte = low 8 bits of the sum of the 12 payload bytes (header excluded).

Reset (rst_n=1 at a clk edge):
- Outputs: all targets 0, target_renew 0, frame_err 0, link_lost 1, frame_cnt 0.
- Internal: FSM to HUNT_H0, counters cleared.
- Reset mid-frame discards partial data; nothing is published.

FSM; bytes are consumed only on cycles with rx_valid=1:
- HUNT_H0: 0xAA -> HUNT_H1; any other byte stays.
- HUNT_H1: 0x55 -> PAYLOAD (byte index 0, running sum 0); 0xAA stays in HUNT_H1 (resync); anything else -> HUNT_H0.
- PAYLOAD: store the byte at its index and add it to the 8-bit running sum. After index 11 -> CHECK.
- CHECK:
  - Byte equal to the running sum: publish and return to HUNT_H0.
  - Mismatch: frame_err pulse, targets unchanged, return to HUNT_H0.

Publish timing and rules:
- Checksum byte accepted at cycle N. At N+1, all four targets update and target_renew=1 for exactly that cycle.
- In the same cycle (N+1): frame_cnt increments, link_lost clears, link watchdog clears.

Clamping, applied at publish:
- pitch, roll and yaw are each saturated to [-ANGLE_LIMIT, +ANGLE_LIMIT].
- height is saturated to [0, HEIGHT_MAX].
- Comparisons are signed, 24-bit.

Byte timeout:
- Active only in HUNT_H1, PAYLOAD and CHECK. The gap counter resets on every rx_valid.
- When the counter reaches BYTE_TIMEOUT with no byte: frame_err pulse, FSM -> HUNT_H0.
- rx_valid in the expiry cycle takes precedence: the byte is consumed and there is no timeout.

Link watchdog:
- The counter increments every cycle and saturates.
- On reaching LINK_TIMEOUT while link_lost=0:
  - link_lost<=1 and all targets <=0.
  - target_renew pulses once.
  - No further pulses until the next valid frame.
- A valid publish in the same cycle as expiry wins: link_lost stays 0.
- After reset, link_lost=1 with no renew pulse.

Other rules:
- frame_err and target_renew are never high in the same cycle.
- A new header byte arriving during the publish cycle is parsed normally.

Test Plan:
Run the bench with BYTE_TIMEOUT=20 and LINK_TIMEOUT=500.
1. Valid frame: AA 55 00 01 F4 00 00 64 FF FF 9C 00 00 00 F3 -> one cycle after F3: renew=1, height=500, pitch=100, roll=-100, yaw=0, frame_cnt=1, link_lost=0.
2. Same frame with checksum F4 -> frame_err 1-cycle pulse, no renew, targets hold previous values, frame_cnt unchanged.
3. Clamp:
   - Payload height FF FF F6, pitch 00 13 88, roll FF EC 78, yaw 00 00 0A, correct checksum.
   - Expect height=0, pitch=3000, roll=-3000, yaw=10.
4. Resync:
   - Stream 12 34 AA AA 55 followed by the payload and checksum of scenario 1.
   - Expect the frame to be accepted, with values as in scenario 1.
   - Also stream AA 00 55 followed by the frame: the false start is rejected and the frame is accepted.
5. Byte timeout:
   - Send AA 55 plus 4 payload bytes, then idle 21 cycles -> frame_err pulse.
   - Then send a full valid frame -> accepted.
   - A gap of exactly 19 cycles -> no error.
6. Link loss and reset:
   - After a valid frame, idle 500 cycles -> link_lost=1, all targets 0, exactly one renew pulse.
   - Next valid frame -> link_lost=0.
   - Assert rst_n mid-payload -> all outputs at reset values; a subsequent full frame is accepted.

Source files
------------

// File: rtl/rc_frame_parser.sv
// rc_frame_parser
// Upstream command stage for the flight controller. Hunts for 15-byte command
// frames (AA 55, four big-endian 24-bit targets, additive checksum) in the
// UART byte stream. Valid targets are clamped and published with a one-cycle
// renew strobe. A link watchdog forces zero targets once when the ground link
// goes silent.
//
// Ports:
//   clk           50 MHz system clock
//   rst_n         synchronous reset, active high (1 = reset)
//   rx_data       received byte
//   rx_valid      one-cycle strobe, rx_data valid
//   target_renew  one-cycle pulse, targets updated this cycle
//   target_*      signed 24-bit height / pitch / roll / yaw targets
//   frame_err     one-cycle pulse on checksum failure or byte timeout
//   frame_cnt     count of accepted frames, wraps at 255
//   link_lost     level, no valid frame within LINK_TIMEOUT cycles
module rc_frame_parser #(
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter int unsigned LINK_TIMEOUT = 25000000,
    parameter int          ANGLE_LIMIT  = 3000,
    parameter int          HEIGHT_MAX   = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        target_renew,
    output logic [23:0] target_height,
    output logic [23:0] target_pitch,
    output logic [23:0] target_roll,
    output logic [23:0] target_yaw,
    output logic        frame_err,
    output logic        link_lost,
    output logic [7:0]  frame_cnt
);

    localparam int GAP_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);

    localparam logic signed [23:0] HMAX = 24'(HEIGHT_MAX);
    localparam logic signed [23:0] AMAX = 24'(ANGLE_LIMIT);
    localparam logic signed [23:0] AMIN = 24'(-ANGLE_LIMIT);

    typedef enum logic [1:0] {
        HUNT_H0,
        HUNT_H1,
        PAYLOAD,
        CHECK
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          byteIdx_q;
    logic [7:0]          sum_q;
    logic [95:0]         payload_q;
    logic [GAP_W-1:0]    gapCnt_q;
    logic [LINK_W-1:0]   linkCnt_q;
    logic                renew_q, frameErr_q, linkLost_q;
    logic [7:0]          frameCnt_q;
    logic [23:0]         height_q, pitch_q, roll_q, yaw_q;

    logic publishFrame, checksumBad, gapExpired, frameErrEvent, linkExpire;
    logic signed [23:0] rawHeight, rawPitch, rawRoll, rawYaw;
    logic signed [23:0] clampHeight, clampPitch, clampRoll, clampYaw;

    function automatic logic signed [23:0] clampAngle(input logic signed [23:0] v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    // Payload is shifted in MSB-first, so the first field received (height)
    // ends up in the top 24 bits once all twelve bytes are in.
    assign rawHeight = $signed(payload_q[95:72]);
    assign rawPitch  = $signed(payload_q[71:48]);
    assign rawRoll   = $signed(payload_q[47:24]);
    assign rawYaw    = $signed(payload_q[23:0]);

    assign clampHeight = (rawHeight < 24'sd0) ? 24'sd0 :
                         (rawHeight > HMAX)   ? HMAX   : rawHeight;
    assign clampPitch  = clampAngle(rawPitch);
    assign clampRoll   = clampAngle(rawRoll);
    assign clampYaw    = clampAngle(rawYaw);

    // Next-state logic and the per-cycle frame events. A byte arriving in the
    // expiry cycle suppresses the timeout. The watchdog yields to a publish
    // and is deferred by a frame error so renew and frame_err never overlap;
    // its counter saturates, so a deferred expiry fires on the next cycle.
    always_comb begin
        state_d      = state_q;
        publishFrame = 1'b0;
        checksumBad  = 1'b0;
        gapExpired   = (state_q != HUNT_H0) && !rx_valid &&
                       (gapCnt_q == GAP_W'(BYTE_TIMEOUT));

        case (state_q)
            HUNT_H0: begin
                if (rx_valid && rx_data == 8'hAA) state_d = HUNT_H1;
            end
            HUNT_H1: begin
                if (rx_valid) begin
                    if (rx_data == 8'h55)      state_d = PAYLOAD;
                    else if (rx_data == 8'hAA) state_d = HUNT_H1;
                    else                       state_d = HUNT_H0;
                end
            end
            PAYLOAD: begin
                if (rx_valid && byteIdx_q == 4'd11) state_d = CHECK;
            end
            CHECK: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) publishFrame = 1'b1;
                    else                  checksumBad  = 1'b1;
                    state_d = HUNT_H0;
                end
            end
            default: state_d = HUNT_H0;
        endcase

        if (gapExpired) state_d = HUNT_H0;

        frameErrEvent = checksumBad || gapExpired;
        linkExpire    = (linkCnt_q == LINK_W'(LINK_TIMEOUT)) && !linkLost_q &&
                        !publishFrame && !frameErrEvent;
    end

    // State register plus frame datapath, watchdog and published outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= HUNT_H0;
            byteIdx_q   <= 4'd0;
            sum_q       <= 8'd0;
            payload_q   <= 96'd0;
            gapCnt_q    <= '0;
            linkCnt_q   <= '0;
            renew_q     <= 1'b0;
            frameErr_q  <= 1'b0;
            linkLost_q  <= 1'b1;
            frameCnt_q  <= 8'd0;
            height_q    <= 24'd0;
            pitch_q     <= 24'd0;
            roll_q      <= 24'd0;
            yaw_q       <= 24'd0;
        end else begin
            state_q <= state_d;

            if (state_q == HUNT_H1 && rx_valid && rx_data == 8'h55) begin
                byteIdx_q <= 4'd0;
                sum_q     <= 8'd0;
            end else if (state_q == PAYLOAD && rx_valid) begin
                payload_q <= {payload_q[87:0], rx_data};
                sum_q     <= sum_q + rx_data;
                byteIdx_q <= byteIdx_q + 4'd1;
            end

            if (rx_valid || state_q == HUNT_H0)
                gapCnt_q <= '0;
            else if (gapCnt_q != GAP_W'(BYTE_TIMEOUT))
                gapCnt_q <= gapCnt_q + 1'b1;

            if (publishFrame)
                linkCnt_q <= '0;
            else if (linkCnt_q != LINK_W'(LINK_TIMEOUT))
                linkCnt_q <= linkCnt_q + 1'b1;

            renew_q    <= publishFrame || linkExpire;
            frameErr_q <= frameErrEvent;

            if (publishFrame) begin
                height_q   <= clampHeight;
                pitch_q    <= clampPitch;
                roll_q     <= clampRoll;
                yaw_q      <= clampYaw;
                linkLost_q <= 1'b0;
                frameCnt_q <= frameCnt_q + 8'd1;
            end else if (linkExpire) begin
                height_q   <= 24'd0;
                pitch_q    <= 24'd0;
                roll_q     <= 24'd0;
                yaw_q      <= 24'd0;
                linkLost_q <= 1'b1;
            end
        end
    end

    assign target_renew  = renew_q;
    assign target_height = height_q;
    assign target_pitch  = pitch_q;
    assign target_roll   = roll_q;
    assign target_yaw    = yaw_q;
    assign frame_err     = frameErr_q;
    assign link_lost     = linkLost_q;
    assign frame_cnt     = frameCnt_q;

endmodule

// File: tb/tb_rc_frame_parser.sv
// tb_rc_frame_parser
// Directed and randomized frames for rc_frame_parser, with expected targets
// computed from the frame format arithmetic (decode, clamp, count).
module tb_rc_frame_parser;

    localparam int BT = 20;
    localparam int LT = 500;
    localparam int AL = 3000;
    localparam int HM = 200000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        target_renew;
    logic [23:0] target_height, target_pitch, target_roll, target_yaw;
    logic        frame_err;
    logic        link_lost;
    logic [7:0]  frame_cnt;

    // 100 MHz bench clock
    always #5 clk = ~clk;

    rc_frame_parser #(
        .BYTE_TIMEOUT(BT),
        .LINK_TIMEOUT(LT),
        .ANGLE_LIMIT (AL),
        .HEIGHT_MAX  (HM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .target_renew (target_renew),
        .target_height(target_height),
        .target_pitch (target_pitch),
        .target_roll  (target_roll),
        .target_yaw   (target_yaw),
        .frame_err    (frame_err),
        .link_lost    (link_lost),
        .frame_cnt    (frame_cnt)
    );

    int vectors    = 0;
    int miscompares = 0;

    int expH, expP, expR, expY, expCnt;
    bit expLost;

    logic [7:0] pay [12];

    // One comparison point: counts every vector and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle, landing just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic int s24(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
        int v;
        v = int'(b0) * 65536 + int'(b1) * 256 + int'(b2);
        if (v >= 8388608) v = v - 16777216;
        return v;
    endfunction

    function automatic int clampI(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic loadFields(input int h, input int p, input int r, input int y);
        int f [4];
        f[0] = h; f[1] = p; f[2] = r; f[3] = y;
        for (int i = 0; i < 4; i++) begin
            pay[3*i]     = f[i][23:16];
            pay[3*i + 1] = f[i][15:8];
            pay[3*i + 2] = f[i][7:0];
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".height"}, 32'(target_height), 32'(expH[23:0]));
        checkOutput({tag, ".pitch"},  32'(target_pitch),  32'(expP[23:0]));
        checkOutput({tag, ".roll"},   32'(target_roll),   32'(expR[23:0]));
        checkOutput({tag, ".yaw"},    32'(target_yaw),    32'(expY[23:0]));
        checkOutput({tag, ".cnt"},    32'(frame_cnt),     32'(expCnt[7:0]));
        checkOutput({tag, ".lost"},   32'(link_lost),     32'(expLost));
    endtask

    task automatic modelReset();
        expH = 0; expP = 0; expR = 0; expY = 0; expCnt = 0; expLost = 1'b1;
    endtask

    // Sends the frame in pay[] (optionally with header, optional idle gap
    // before payload byte gapAt) and checks the cycle after the checksum.
    task automatic applyStimulus(input string tag, input bit badSum,
                                 input bit withHeader, input int gapAt,
                                 input int gapLen);
        logic [7:0] sum;
        int errs;
        sum  = 8'd0;
        errs = 0;
        if (withHeader) begin
            sendByte(8'hAA);
            sendByte(8'h55);
        end
        for (int i = 0; i < 12; i++) begin
            if (i == gapAt) begin
                for (int g = 0; g < gapLen; g++) begin
                    tick();
                    if (frame_err) errs++;
                end
            end
            sendByte(pay[i]);
            sum = sum + pay[i];
        end
        if (gapLen > 0) checkOutput({tag, ".gapNoErr"}, 32'(errs), 32'd0);
        sendByte(badSum ? sum + 8'd1 : sum);
        if (!badSum) begin
            expH    = clampI(s24(pay[0], pay[1], pay[2]), 0, HM);
            expP    = clampI(s24(pay[3], pay[4], pay[5]), -AL, AL);
            expR    = clampI(s24(pay[6], pay[7], pay[8]), -AL, AL);
            expY    = clampI(s24(pay[9], pay[10], pay[11]), -AL, AL);
            expCnt  = (expCnt + 1) % 256;
            expLost = 1'b0;
        end
        checkOutput({tag, ".renew"}, 32'(target_renew), 32'(!badSum));
        checkOutput({tag, ".err"},   32'(frame_err),    32'(badSum));
        checkState(tag);
        tick();
        checkOutput({tag, ".renewEnd"}, 32'(target_renew), 32'd0);
        checkOutput({tag, ".errEnd"},   32'(frame_err),    32'd0);
    endtask

    function automatic int randField();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 16777215)) - 8388608;
            1:       return int'($urandom_range(0, 12000)) - 6000;
            default: return int'($urandom_range(0, 400000)) - 100000;
        endcase
    endfunction

    initial begin
        int errs, renews;
        logic [7:0] junk;

        rst_n    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        rst_n = 1'b0;
        modelReset();
        checkOutput("reset.renew", 32'(target_renew), 32'd0);
        checkOutput("reset.err",   32'(frame_err),    32'd0);
        checkState("reset");

        // Valid frame, then the same frame with a wrong checksum
        loadFields(500, 100, -100, 0);
        applyStimulus("valid", 1'b0, 1'b1, -1, 0);
        applyStimulus("badsum", 1'b1, 1'b1, -1, 0);

        // Clamping on every field
        loadFields(-10, 5000, -5000, 10);
        applyStimulus("clamp", 1'b0, 1'b1, -1, 0);

        // Resync through junk and a repeated 0xAA
        sendByte(8'h12); sendByte(8'h34); sendByte(8'hAA); sendByte(8'hAA); sendByte(8'h55);
        loadFields(500, 100, -100, 0);
        applyStimulus("resync", 1'b0, 1'b0, -1, 0);

        // False start AA 00 55 followed by a real frame
        sendByte(8'hAA); sendByte(8'h00); sendByte(8'h55);
        loadFields(1234, -2999, 2999, -1);
        applyStimulus("falsestart", 1'b0, 1'b1, -1, 0);

        // Byte timeout mid-payload
        sendByte(8'hAA); sendByte(8'h55);
        for (int i = 0; i < 4; i++) sendByte(pay[i]);
        errs = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (frame_err) errs++;
            if (i == 18) checkOutput("timeout.none19", 32'(errs), 32'd0);
            checkOutput("timeout.noRenew", 32'(target_renew), 32'd0);
        end
        checkOutput("timeout.pulse", 32'(errs), 32'd1);
        checkState("timeout.hold");
        loadFields(200001, 3001, -3001, 0);
        applyStimulus("aftertimeout", 1'b0, 1'b1, -1, 0);

        // 19-cycle gap inside a frame is tolerated
        loadFields(7, 8, 9, 10);
        applyStimulus("gap19", 1'b0, 1'b1, 4, BT - 1);

        // Randomized frames with optional junk, gaps and bad checksums
        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                junk = 8'($urandom_range(0, 254));
                if (junk == 8'hAA) junk = 8'h00;
                sendByte(junk);
            end
            loadFields(randField(), randField(), randField(), randField());
            applyStimulus("rand", ($urandom_range(0, 4) == 0), 1'b1,
                          int'($urandom_range(0, 11)), int'($urandom_range(0, 5)));
        end

        // Link loss after a valid frame
        loadFields(1000, 50, -50, 5);
        applyStimulus("prelink", 1'b0, 1'b1, -1, 0);
        renews = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (target_renew) renews++;
            if (i == 480) checkOutput("link.stillUp", 32'(link_lost), 32'd0);
        end
        expH = 0; expP = 0; expR = 0; expY = 0; expLost = 1'b1;
        checkOutput("link.renewPulses", 32'(renews), 32'd1);
        checkState("link.lost");
        applyStimulus("relink", 1'b0, 1'b1, -1, 0);

        // Reset mid-payload discards the partial frame
        sendByte(8'hAA); sendByte(8'h55);
        for (int i = 0; i < 5; i++) sendByte(pay[i]);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        modelReset();
        checkOutput("midreset.renew", 32'(target_renew), 32'd0);
        checkOutput("midreset.err",   32'(frame_err),    32'd0);
        checkState("midreset");
        loadFields(42, -42, 100, -100);
        applyStimulus("afterreset", 1'b0, 1'b1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
